// File: rtl/cordic_angle_gen.sv
// cordic_angle_gen
//   Command stage ahead of the CORDIC rotation/PWM block. A signed speed
//   command is slew-limited into spd_cur. spd_cur is integrated into a
//   wrapping ANG_W-bit phase accumulator once every TICK_DIV clocks. Each
//   step offers one {x_, y_, ang} sample over a valid/ready handshake.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   en                1 = run toward spd_cmd, 0 = ramp down to zero, then idle
//   spd_cmd           signed target speed, angle LSBs per step
//   x_in, y_in        vector components, sampled when a step loads the output
//   x_, y_, ang       registered sample presented to the CORDIC
//   out_valid         sample pending; out_ready accepts it
//   spd_cur           current slew-limited speed
//   running           FSM not idle
//   ovr               sticky: a step found the previous sample still pending
module cordic_angle_gen #(
  parameter int ANG_W    = 20,
  parameter int XY_W     = 10,
  parameter int SPD_W    = 12,
  parameter int TICK_DIV = 5120,
  parameter int ACC_STEP = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [SPD_W-1:0] spd_cmd,
  input  logic        [XY_W-1:0]  x_in,
  input  logic        [XY_W-1:0]  y_in,
  output logic        [XY_W-1:0]  x_,
  output logic        [XY_W-1:0]  y_,
  output logic        [ANG_W-1:0] ang,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [SPD_W-1:0] spd_cur,
  output logic                    running,
  output logic                    ovr
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic signed [SPD_W:0] STEP_POS = (SPD_W+1)'(ACC_STEP);
  localparam logic signed [SPD_W:0] STEP_NEG = -STEP_POS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [SPD_W-1:0] spd_q, spd_d;
  logic        [ANG_W-1:0] acc_q, acc_d;
  logic        [XY_W-1:0]  x_q, x_d;
  logic        [XY_W-1:0]  y_q, y_d;
  logic        [ANG_W-1:0] ang_q, ang_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;

  logic                    step;
  logic signed [SPD_W:0]   target;
  logic signed [SPD_W:0]   diff;
  logic signed [SPD_W-1:0] spd_next;
  logic        [ANG_W-1:0] acc_next;

  // Slew limiter: the difference is taken one bit wider so that extreme
  // targets cannot overflow. Inside the ACC_STEP window spd_cur lands exactly
  // on the target, so it never overshoots.
  always_comb begin
    target   = (state_q == RUN) ? {spd_cmd[SPD_W-1], spd_cmd} : '0;
    diff     = target - {spd_q[SPD_W-1], spd_q};
    spd_next = target[SPD_W-1:0];
    if (diff > STEP_POS) begin
      spd_next = spd_q + SPD_W'(ACC_STEP);
    end else if (diff < STEP_NEG) begin
      spd_next = spd_q - SPD_W'(ACC_STEP);
    end
    acc_next = acc_q + {{(ANG_W-SPD_W){spd_next[SPD_W-1]}}, spd_next};
  end

  // Tick counter, FSM, and speed/phase integration.
  // Leaving RUN does not wait for the counter, so stopping takes effect on
  // the very next clock. STOP returns to RUN with the counter and speed intact.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    spd_d   = spd_q;
    acc_d   = acc_q;
    step    = (state_q != IDLE) && (cnt_q == CNT_LAST);
    if (state_q != IDLE) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
    if (step) begin
      spd_d = spd_next;
      acc_d = acc_next;
    end
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) state_d = STOP;
      end
      STOP: begin
        if (en) begin
          state_d = RUN;
        end else if (step && (spd_next == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register. A step reloads the register only when the slot is free
  // or is being accepted on this same edge. A step that finds the slot still
  // pending only sets the sticky overrun flag.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    ang_d   = ang_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (step && (!valid_q || out_ready)) begin
      x_d     = x_in;
      y_d     = y_in;
      ang_d   = acc_next;
      valid_d = 1'b1;
    end else begin
      if (valid_q && out_ready) valid_d = 1'b0;
      if (step) ovr_d = 1'b1;
    end
  end

  // All state registers share one asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      spd_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ang_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spd_q   <= spd_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ang_q   <= ang_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign x_        = x_q;
  assign y_        = y_q;
  assign ang       = ang_q;
  assign out_valid = valid_q;
  assign spd_cur   = spd_q;
  assign running   = (state_q != IDLE);
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_cordic_angle_gen.sv
// tb_cordic_angle_gen
//   Directed bench for cordic_angle_gen with TICK_DIV=4, ACC_STEP=16.
//   Expected samples are queued when stimulus is issued. A monitor pops one
//   entry for every handshake the DUT completes.
module tb_cordic_angle_gen;

  localparam int ANG_W    = 20;
  localparam int XY_W     = 10;
  localparam int SPD_W    = 12;
  localparam int TICK_DIV = 4;
  localparam int ACC_STEP = 16;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic signed [SPD_W-1:0] spd_cmd;
  logic        [XY_W-1:0]  x_in;
  logic        [XY_W-1:0]  y_in;
  logic        [XY_W-1:0]  x_;
  logic        [XY_W-1:0]  y_;
  logic        [ANG_W-1:0] ang;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [SPD_W-1:0] spd_cur;
  logic                    running;
  logic                    ovr;

  typedef struct {
    int ang;
    int x;
    int y;
  } sample_t;

  sample_t expQ[$];
  int      tests = 0;
  int      fails = 0;
  int      cyc;
  logic    sawValid;
  logic    checkRun = 1'b0;
  logic    sawIdle  = 1'b0;

  cordic_angle_gen #(
    .ANG_W(ANG_W), .XY_W(XY_W), .SPD_W(SPD_W),
    .TICK_DIV(TICK_DIV), .ACC_STEP(ACC_STEP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .spd_cmd(spd_cmd),
    .x_in(x_in), .y_in(y_in), .x_(x_), .y_(y_), .ang(ang),
    .out_valid(out_valid), .out_ready(out_ready),
    .spd_cur(spd_cur), .running(running), .ovr(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input int spd, input int x, input int y);
    en      = e;
    spd_cmd = SPD_W'(spd);
    x_in    = XY_W'(x);
    y_in    = XY_W'(y);
  endtask

  task automatic pushExp(input int a, input int x, input int y);
    sample_t s;
    s.ang = a;
    s.x   = x;
    s.y   = y;
    expQ.push_back(s);
  endtask

  // Returns the number of falling edges until out_valid is seen high.
  task automatic waitValid(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!out_valid && cycles < 4*TICK_DIV + 8);
    if (!out_valid) begin
      tests++;
      fails++;
      $display("[TB] FAIL waitValid timeout: out_valid=%0b after %0d cycles, required 1", out_valid, cycles);
    end
  endtask

  task automatic measureFirstStep(output int cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!running && n < 10);
    if (!running) begin
      tests++;
      fails++;
      $display("[TB] FAIL running timeout: running=%0b, required 1", running);
    end
    waitValid(cycles);
  endtask

  // Scoreboard monitor: a handshake completes on the next rising edge
  // whenever valid and ready are both high at the falling edge.
  always @(negedge clk) begin : monitor
    sample_t s;
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected sample: ang=0x%0h, required no sample", ang);
      end else begin
        s = expQ.pop_front();
        checkOutput("sample ang", int'(ang), s.ang);
        checkOutput("sample x", int'(x_), s.x);
        checkOutput("sample y", int'(y_), s.y);
      end
    end
  end

  always @(negedge clk) begin
    if (checkRun && !running) sawIdle = 1'b1;
  end

  initial begin
    int spdDn[9];
    int angDn[9];
    int spdUp[5];
    int angUp[5];
    spdDn = '{24, 8, -8, -24, -32, -32, -32, -32, -32};
    angDn = '{152, 160, 152, 128, 96, 64, 32, 0, 'hFFFE0};
    spdUp = '{-16, 0, 16, 32, 32};
    angUp = '{'hFFFD0, 'hFFFD0, 'hFFFE0, 0, 'h20};

    rst = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: nothing moves and no sample is offered.
    sawValid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("idle no valid", int'(sawValid), 0);
    checkOutput("reset ang", int'(ang), 0);
    checkOutput("reset x", int'(x_), 0);
    checkOutput("reset y", int'(y_), 0);
    checkOutput("reset spd", int'(spd_cur), 0);
    checkOutput("reset running", int'(running), 0);
    checkOutput("reset ovr", int'(ovr), 0);

    // Ramp up toward 40.
    pushExp(16, 'h155, 'h0AA);
    pushExp(48, 'h155, 'h0AA);
    pushExp(88, 'h155, 'h0AA);
    pushExp(128, 'h155, 'h0AA);
    applyStimulus(1'b1, 40, 'h155, 'h0AA);
    measureFirstStep(cyc);
    checkOutput("first step latency", cyc, TICK_DIV);
    checkOutput("ramp spd 1", int'(spd_cur), 16);
    waitValid(cyc);
    checkOutput("step period", cyc, TICK_DIV);
    checkOutput("ramp spd 2", int'(spd_cur), 32);
    waitValid(cyc);
    checkOutput("ramp spd 3", int'(spd_cur), 40);
    waitValid(cyc);
    checkOutput("ramp spd 4", int'(spd_cur), 40);

    // Reverse through zero and wrap the angle downward, then back upward.
    for (int i = 0; i < 9; i++) pushExp(angDn[i], 'h3FF, 'h001);
    applyStimulus(1'b1, -32, 'h3FF, 'h001);
    for (int i = 0; i < 9; i++) begin
      waitValid(cyc);
      checkOutput("reverse spd", int'(spd_cur), spdDn[i]);
    end
    for (int i = 0; i < 5; i++) pushExp(angUp[i], 'h3FF, 'h001);
    applyStimulus(1'b1, 32, 'h3FF, 'h001);
    for (int i = 0; i < 5; i++) begin
      waitValid(cyc);
      checkOutput("forward spd", int'(spd_cur), spdUp[i]);
    end

    // Overrun: hold ready low across three steps.
    checkOutput("ovr before stall", int'(ovr), 0);
    pushExp('h40, 'h123, 'h321);
    pushExp('hA0, 'h0F0, 'h00F);
    applyStimulus(1'b1, 32, 'h123, 'h321);
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 applyStimulus(1'b1, 32, 'h0F0, 'h00F);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("stall ang frozen", int'(ang), 'h40);
    checkOutput("stall x frozen", int'(x_), 'h123);
    checkOutput("stall valid held", int'(out_valid), 1);
    checkOutput("stall ovr set", int'(ovr), 1);
    checkOutput("stall spd", int'(spd_cur), 32);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    waitValid(cyc);
    checkOutput("post stall spd", int'(spd_cur), 32);

    // Ramp down to idle from 40.
    pushExp('hC8, 'h0F0, 'h00F);
    pushExp('hE0, 'h0F0, 'h00F);
    pushExp('hE8, 'h0F0, 'h00F);
    pushExp('hE8, 'h0F0, 'h00F);
    applyStimulus(1'b1, 40, 'h0F0, 'h00F);
    waitValid(cyc);
    checkOutput("pre stop spd", int'(spd_cur), 40);
    en = 1'b0;
    waitValid(cyc);
    checkOutput("stop spd 1", int'(spd_cur), 24);
    checkOutput("stop running 1", int'(running), 1);
    waitValid(cyc);
    checkOutput("stop spd 2", int'(spd_cur), 8);
    waitValid(cyc);
    checkOutput("stop spd 3", int'(spd_cur), 0);
    checkOutput("stop running 3", int'(running), 0);

    // Restart from the retained angle, then bounce through STOP.
    pushExp('hF8, 'h0F0, 'h00F);
    pushExp('h118, 'h0F0, 'h00F);
    pushExp('h128, 'h0F0, 'h00F);
    pushExp('h148, 'h0F0, 'h00F);
    pushExp('h170, 'h0F0, 'h00F);
    en = 1'b1;
    measureFirstStep(cyc);
    checkOutput("restart latency", cyc, TICK_DIV);
    checkOutput("restart spd 1", int'(spd_cur), 16);
    checkRun = 1'b1;
    waitValid(cyc);
    checkOutput("restart spd 2", int'(spd_cur), 32);
    en = 1'b0;
    waitValid(cyc);
    checkOutput("bounce stop spd", int'(spd_cur), 16);
    en = 1'b1;
    waitValid(cyc);
    checkOutput("bounce run spd 1", int'(spd_cur), 32);
    waitValid(cyc);
    checkOutput("bounce run spd 2", int'(spd_cur), 40);
    checkRun = 1'b0;
    checkOutput("bounce never idle", int'(sawIdle), 0);

    // Reset while a sample is pending; that sample is never expected.
    @(posedge clk);
    #1 out_ready = 1'b0;
    waitValid(cyc);
    checkOutput("pending spd", int'(spd_cur), 40);
    #1 rst = 1'b1;
    #1;
    checkOutput("async rst valid", int'(out_valid), 0);
    checkOutput("async rst spd", int'(spd_cur), 0);
    checkOutput("async rst ang", int'(ang), 0);
    checkOutput("async rst running", int'(running), 0);
    checkOutput("async rst ovr", int'(ovr), 0);
    pushExp(16, 'h0F0, 'h00F);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rst = 1'b0;
    measureFirstStep(cyc);
    checkOutput("post rst latency", cyc, TICK_DIV);
    checkOutput("post rst spd", int'(spd_cur), 16);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
